// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
// Two-road intersection light sequencer. Road A and road B take turns through
// green, yellow and all-red phases. A per-phase cycle counter enforces the
// minimum and maximum green times. An optional pedestrian WALK phase can be
// inserted after an all-red clearance.
//
// Optional feature macro: PED_WALK_EN
//   defined   : pedestrian latch, WALK phase, walk/ped_ack outputs active
//   undefined : ped_req ignored, walk/ped_ack tied low, all-red always hands
//               over to the opposing green
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   carA     in   car waiting on road A (level)
//   carB     in   car waiting on road B (level)
//   ped_req  in   pedestrian request pulse (latched)
//   lightA   out  road A lamps, 001 green / 010 yellow / 100 red
//   lightB   out  road B lamps, same encoding
//   walk     out  pedestrian walk lamp
//   ped_ack  out  one-cycle pulse on the first WALK cycle
//   phase    out  current state code
module traffic_phase_scheduler #(
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 10,
  parameter int YELLOW_LEN = 2,
  parameter int ALLRED_LEN = 1,
  parameter int WALK_LEN   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       carA,
  input  logic       carB,
  input  logic       ped_req,
  output logic [2:0] lightA,
  output logic [2:0] lightB,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  localparam logic [2:0] S_A_GREEN  = 3'd0;
  localparam logic [2:0] S_A_YELLOW = 3'd1;
  localparam logic [2:0] S_A_ALLRED = 3'd2;
  localparam logic [2:0] S_B_GREEN  = 3'd3;
  localparam logic [2:0] S_B_YELLOW = 3'd4;
  localparam logic [2:0] S_B_ALLRED = 3'd5;
  localparam logic [2:0] S_WALK     = 3'd6;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  localparam logic [7:0] GMIN_M1 = 8'(GREEN_MIN - 1);
  localparam logic [7:0] GMAX_M1 = 8'(GREEN_MAX - 1);
  localparam logic [7:0] YEL_M1  = 8'(YELLOW_LEN - 1);
  localparam logic [7:0] ARED_M1 = 8'(ALLRED_LEN - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ped_pend;

`ifdef PED_WALK_EN
  localparam logic [7:0] WALK_M1 = 8'(WALK_LEN - 1);

  // after_walk_b_q: 1 = resume at B_GREEN, 0 = resume at A_GREEN
  logic ped_pend_q, ped_pend_d;
  logic after_walk_b_q, after_walk_b_d;

  assign ped_pend = ped_pend_q;

  always_comb begin
    ped_pend_d     = ped_pend_q;
    after_walk_b_d = after_walk_b_q;
    if (ped_req && state_q != S_WALK) ped_pend_d = 1'b1;
    // Entering WALK serves the request; a request on that same edge is lost.
    if (state_d == S_WALK && state_q != S_WALK) ped_pend_d = 1'b0;
    if (state_q == S_A_ALLRED && state_d == S_WALK) after_walk_b_d = 1'b1;
    if (state_q == S_B_ALLRED && state_d == S_WALK) after_walk_b_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pend_q     <= 1'b0;
      after_walk_b_q <= 1'b1;
    end else begin
      ped_pend_q     <= ped_pend_d;
      after_walk_b_q <= after_walk_b_d;
    end
  end

  assign walk    = (state_q == S_WALK);
  assign ped_ack = (state_q == S_WALK) && (cnt_q == 8'd0);
`else
  logic ped_unused;
  assign ped_unused = ped_req | (S_WALK == 3'd0) | (WALK_LEN == 0);
  assign ped_pend   = 1'b0;
  assign walk       = 1'b0;
  assign ped_ack    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      // A green yields early to a lone B car or a pending pedestrian, and
      // is forced off at the max time if B is waiting at all.
      S_A_GREEN:
        if ((cnt_q >= GMIN_M1 && ((carB && !carA) || ped_pend)) ||
            (cnt_q >= GMAX_M1 && carB))
          state_d = S_A_YELLOW;
      S_B_GREEN:
        if ((cnt_q >= GMIN_M1 && ((carA && !carB) || ped_pend)) ||
            (cnt_q >= GMAX_M1 && carA))
          state_d = S_B_YELLOW;
      S_A_YELLOW: if (cnt_q == YEL_M1) state_d = S_A_ALLRED;
      S_B_YELLOW: if (cnt_q == YEL_M1) state_d = S_B_ALLRED;
`ifdef PED_WALK_EN
      S_A_ALLRED: if (cnt_q == ARED_M1) state_d = ped_pend ? S_WALK : S_B_GREEN;
      S_B_ALLRED: if (cnt_q == ARED_M1) state_d = ped_pend ? S_WALK : S_A_GREEN;
      S_WALK:     if (cnt_q == WALK_M1) state_d = after_walk_b_q ? S_B_GREEN : S_A_GREEN;
`else
      S_A_ALLRED: if (cnt_q == ARED_M1) state_d = S_B_GREEN;
      S_B_ALLRED: if (cnt_q == ARED_M1) state_d = S_A_GREEN;
`endif
      default:    state_d = S_A_GREEN;
    endcase
  end

  // Counter restarts on any state change and otherwise saturates at 255.
  always_comb begin
    if (state_d != state_q)  cnt_d = 8'd0;
    else if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    else                     cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_A_GREEN;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    lightA = LAMP_RED;
    lightB = LAMP_RED;
    case (state_q)
      S_A_GREEN:  lightA = LAMP_GREEN;
      S_A_YELLOW: lightA = LAMP_YELLOW;
      S_B_GREEN:  lightB = LAMP_GREEN;
      S_B_YELLOW: lightB = LAMP_YELLOW;
      default:    ;
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;

  localparam int GREEN_MIN  = 4;
  localparam int GREEN_MAX  = 10;
  localparam int YELLOW_LEN = 2;
  localparam int ALLRED_LEN = 1;
  localparam int WALK_LEN   = 6;
`ifdef PED_WALK_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       carA = 1'b0;
  logic       carB = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] lightA, lightB, phase;
  logic       walk, ped_ack;

  traffic_phase_scheduler #(
    .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .YELLOW_LEN(YELLOW_LEN),
    .ALLRED_LEN(ALLRED_LEN), .WALK_LEN(WALK_LEN)
  ) dut (
    .clk(clk), .rst(rst), .carA(carA), .carB(carB), .ped_req(ped_req),
    .lightA(lightA), .lightB(lightB), .walk(walk), .ped_ack(ped_ack),
    .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [2:0] la;
    logic [2:0] lb;
    logic       w;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, req);
    end
  endtask

  // Reference model: phase name + time spent in it, rules taken directly
  // from the intersection behaviour (phase numbers are the published codes).
  int ph  = 0;
  int el  = 0;
  bit pend = 0;
  int aw  = 3;

  function automatic exp_t lamps_of(input int p, input int e);
    exp_t r;
    r.ph  = 3'(p);
    r.la  = 3'b100;
    r.lb  = 3'b100;
    if (p == 0) r.la = 3'b001;
    if (p == 1) r.la = 3'b010;
    if (p == 3) r.lb = 3'b001;
    if (p == 4) r.lb = 3'b010;
    r.w   = (p == 6);
    r.ack = (p == 6) && (e == 0);
    return r;
  endfunction

  task automatic model_step(input bit r, input bit a, input bit b, input bit p);
    int nx;
    if (r) begin
      ph = 0; el = 0; pend = 0; aw = 3;
      return;
    end
    nx = ph;
    if (ph == 0 && ((el >= GREEN_MIN - 1 && ((b && !a) || pend)) || (el >= GREEN_MAX - 1 && b))) nx = 1;
    if (ph == 3 && ((el >= GREEN_MIN - 1 && ((a && !b) || pend)) || (el >= GREEN_MAX - 1 && a))) nx = 4;
    if ((ph == 1 || ph == 4) && el == YELLOW_LEN - 1) nx = ph + 1;
    if ((ph == 2 || ph == 5) && el == ALLRED_LEN - 1) begin
      if (PED && pend) begin
        nx = 6;
        aw = (ph == 2) ? 3 : 0;
      end else begin
        nx = (ph == 2) ? 3 : 0;
      end
    end
    if (ph == 6 && el == WALK_LEN - 1) nx = aw;
    if (PED && p && ph != 6) pend = 1;
    if (nx == 6 && ph != 6) pend = 0;
    el = (nx == ph) ? el + 1 : 0;
    ph = nx;
  endtask

  // One cycle of stimulus: optional directed phase check on the current
  // cycle, then drive inputs and queue the model's prediction for next cycle.
  task automatic drive_cycle(input bit r, input bit a, input bit b, input bit p, input int dir_ph);
    @(negedge clk);
    if (dir_ph >= 0) chk("dir_phase", int'(phase), dir_ph);
    rst = r; carA = a; carB = b; ped_req = p;
    model_step(r, a, b, p);
    exp_q.push_back(lamps_of(ph, el));
  endtask

  task automatic do_reset();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, -1);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, -1);
  endtask

  // Monitor: outputs are valid every cycle; compare just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("phase",   int'(phase),   int'(e.ph));
        chk("lightA",  int'(lightA),  int'(e.la));
        chk("lightB",  int'(lightB),  int'(e.lb));
        chk("walk",    int'(walk),    int'(e.w));
        chk("ped_ack", int'(ped_ack), int'(e.ack));
      end
    end
  end

  initial begin
    int  ex;
    bit  a, b;
    // A only: green holds indefinitely
    do_reset();
    for (int k = 0; k < 30; k++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);

    // B only: min-green hand-over
    do_reset();
    for (int k = 0; k < 12; k++) begin
      ex = (k < 4) ? 0 : (k < 6) ? 1 : (k == 6) ? 2 : 3;
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, ex);
    end

    // Both roads busy: max-green hand-over each way
    do_reset();
    for (int k = 0; k < 25; k++) begin
      ex = (k < 10) ? 0 : (k < 12) ? 1 : (k == 12) ? 2 : (k < 23) ? 3 : 4;
      drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, ex);
    end

    // Pedestrian request at cycle 1, a second one during WALK is dropped
    do_reset();
    for (int k = 0; k < 40; k++) begin
      if (PED) ex = (k < 4) ? 0 : (k < 6) ? 1 : (k == 6) ? 2 : (k < 13) ? 6 : (k == 13) ? 3 : -1;
      else     ex = 0;
      drive_cycle(1'b0, 1'b1, 1'b0, (k == 1 || k == 9), ex);
    end

    // Reset in the middle of A_YELLOW
    do_reset();
    for (int k = 0; k < 14; k++) begin
      ex = (k < 4) ? 0 : (k < 6) ? 1 : (k < 10) ? 0 : (k < 12) ? 1 : -1;
      drive_cycle(k == 5, 1'b0, 1'b1, 1'b0, ex);
    end

    // Randomized traffic, pedestrians and occasional resets
    do_reset();
    a = 1'b0; b = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(7) == 0) a = ~a;
      if ($urandom_range(7) == 0) b = ~b;
      drive_cycle($urandom_range(299) == 0, a, b, $urandom_range(15) == 0, -1);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Timed two-road intersection scheduler that sequences the A/B traffic lights through green, yellow and all-red phases. Minimum and maximum green times are enforced by a per-phase cycle counter, and an optional pedestrian walk phase is inserted between road phases. It sits above the car sensors and drives the `lightA`/`lightB` lamp outputs with the team's one-hot lamp encoding.

## Interface
- `GREEN_MIN`, default 4: minimum green length in cycles (1..255).
- `GREEN_MAX`, default 10: maximum green length in cycles when the opposing road waits (GREEN_MIN..255).
- `YELLOW_LEN`, default 2: yellow length in cycles (1..255).
- `ALLRED_LEN`, default 1: all-red clearance length in cycles (1..255).
- `WALK_LEN`, default 6: pedestrian walk length in cycles (1..255).
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `carA`  in  1: car waiting on road A (level).
- `carB`  in  1: car waiting on road B (level).
- `ped_req`  in  1: pedestrian request; any 1-cycle pulse is latched.
- `lightA`  out  3: road A lamps; 3'b001 green, 3'b010 yellow, 3'b100 red.
- `lightB`  out  3: road B lamps, same encoding.
- `walk`  out  1: pedestrian walk lamp.
- `ped_ack`  out  1: 1-cycle pulse on the first WALK cycle.
- `phase`  out  3: current state code.

## Operation
- States and codes: A_GREEN 0, A_YELLOW 1, A_ALLRED 2, B_GREEN 3, B_YELLOW 4, B_ALLRED 5, WALK 6. Codes 7 and any illegal value go to A_GREEN on the next edge.
- Lamps are Moore outputs decoded from the state register:
  - A_GREEN: A=001, B=100.
  - A_YELLOW: A=010, B=100.
  - B_GREEN: A=100, B=001.
  - B_YELLOW: A=100, B=010.
  - ALLRED and WALK: A=100, B=100.
  - `walk`=1 only in WALK.
- `cnt` (8 bits): cleared on every state change; otherwise incremented each cycle, saturating at 255.
- `ped_pend` latch: set by `ped_req`=1 in any state except WALK (requests during WALK are dropped); cleared on the edge entering WALK.
- A_GREEN transitions:
  - To A_YELLOW when `cnt`>=GREEN_MIN-1 and ((carB && !carA) || ped_pend).
  - To A_YELLOW when `cnt`>=GREEN_MAX-1 and carB.
  - Otherwise stay, including indefinitely when carB=0 and ped_pend=0.
- B_GREEN: symmetric to A_GREEN, with A and B swapped.
- A_YELLOW and B_YELLOW: exit when `cnt`==YELLOW_LEN-1, to A_ALLRED and B_ALLRED respectively.
- A_ALLRED and B_ALLRED: exit when `cnt`==ALLRED_LEN-1.
  - If ped_pend: go to WALK and record `after_walk` = B_GREEN (from A_ALLRED) or A_GREEN (from B_ALLRED).
  - Else: go to B_GREEN (from A_ALLRED) or A_GREEN (from B_ALLRED).
- WALK: exit to `after_walk` when `cnt`==WALK_LEN-1.
- Simultaneous events:
  - `ped_req` on the same edge that enters WALK is dropped.
  - carA and carB both high: the current green holds until GREEN_MAX, then yields.

## Timing
- Reset (`rst` high at an edge): state=A_GREEN, `cnt`=0, ped_pend=0, `after_walk`=B_GREEN. Outputs during and after reset: lightA=001, lightB=100, walk=0, ped_ack=0, phase=0.
- Reset mid-phase (including WALK) aborts the phase immediately on that edge. There is no yellow on reset.
- Cycle 0 is the first cycle with `rst` low. Lamp outputs change on the same edge as the state register, with no extra latency.
- A green lasts at least GREEN_MIN cycles. Yellow lasts exactly YELLOW_LEN cycles, all-red exactly ALLRED_LEN cycles, and WALK exactly WALK_LEN cycles.
- Inputs are sampled at every rising edge. No input synchronisation is performed in this block.

## Configuration
- `PED_WALK_EN` defined: pedestrian logic is present as described above.
- `PED_WALK_EN` undefined:
  - ped_pend, `after_walk`, the WALK state and the WALK_LEN check are removed.
  - `ped_req` is ignored.
  - `walk` and `ped_ack` are tied to 0.
  - ALLRED always proceeds to the opposing green.

## Test plan
- Reset, then carA=1, carB=0 for 30 cycles: phase=0, lightA=001, lightB=100 throughout.
- carA=0, carB=1 from cycle 0:
  - A_GREEN for cycles 0–3.
  - A_YELLOW for cycles 4–5 (lightA=010).
  - A_ALLRED at cycle 6.
  - B_GREEN from cycle 7 (lightB=001).
- carA=carB=1 from cycle 0:
  - A_GREEN for cycles 0–9.
  - A_YELLOW for cycles 10–11.
  - A_ALLRED at cycle 12.
  - B_GREEN at cycle 13.
  - B_GREEN holds until cycle 22, then B_YELLOW.
- `PED_WALK_EN` defined, carA=1, carB=0, `ped_req` pulse at cycle 1:
  - A_YELLOW for cycles 4–5.
  - ALLRED at cycle 6.
  - WALK for cycles 7–12, with walk=1 and both lamps 100.
  - ped_ack=1 only at cycle 7.
  - B_GREEN at cycle 13.
- `ped_req` pulse at cycle 9, during WALK of the previous scenario: ignored. After WALK there is no second WALK and ped_ack stays 0.
- carB=1, `rst` pulsed at cycle 5 (A_YELLOW): at cycle 6, phase=0, lightA=001 and `cnt` restarts. A_YELLOW is reached again 4 cycles after `rst` drops.
- `PED_WALK_EN` undefined, same stimulus as the pedestrian scenario: A_GREEN is held for all cycles, walk=0 and ped_ack=0.
